// File: rtl/as_4b_pkg.sv
// -----------------------------------------------------------------------------
// as_4b_pkg
// Shared constants for the registered adder/subtractor.
//   MODE_ADD / MODE_SUB : encoding of the 'mode' input.
//   AS_WIDTH            : default operand/result width.
// -----------------------------------------------------------------------------
package as_4b_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int AS_WIDTH = 4;

endpackage : as_4b_pkg

// File: rtl/as_4b_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, chained by as_4b into a ripple-carry adder.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/as_4b.sv
// -----------------------------------------------------------------------------
// as_4b
// Registered WIDTH-bit adder/subtractor with carry/borrow, signed overflow and
// zero flags. Subtraction is A + ~B + 1 through the same ripple chain.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears every output
//   A, B       : operands (unsigned or two's complement)
//   mode       : MODE_ADD (A+B) or MODE_SUB (A-B)
//   result     : registered sum/difference modulo 2^WIDTH
//   carry_out  : registered carry (add) or borrow (subtract)
//   overflow   : registered two's-complement overflow
//   zero       : registered flag, set when result is zero
//   out_valid  : low in reset, high from the first edge after release
// -----------------------------------------------------------------------------
module as_4b
    import as_4b_pkg::*;
#(
    parameter int WIDTH = AS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic             w_sub;
    logic [WIDTH-1:0] w_bInv;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic             w_carryFlag;
    logic             w_overflow;
    logic             w_zero;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_valid;

    // Subtraction inverts B and injects a carry-in of 1 (two's complement).
    assign w_sub      = (mode == MODE_SUB);
    assign w_bInv     = B ^ {WIDTH{w_sub}};
    assign w_carry[0] = w_sub;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gAdder
            full_adder uFa (
                .a    (A[gi]),
                .b    (w_bInv[gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // In subtract mode a missing carry out of the MSB means a borrow occurred.
    assign w_carryFlag = w_carry[WIDTH] ^ w_sub;
    // Carry into the MSB differing from carry out of it signals signed overflow.
    assign w_overflow  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
    // Taken from the combinational sum so it lands in the same cycle as result.
    assign w_zero      = ~|w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_result   <= w_sum;
            r_carry    <= w_carryFlag;
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
            r_valid    <= 1'b1;
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign out_valid = r_valid;

endmodule : as_4b

// File: tb/tb_as_4b.sv
// -----------------------------------------------------------------------------
// tb_as_4b
// Self-checking bench for as_4b: an arithmetic reference model predicts every
// registered output, a compare process checks it each falling clock edge, and
// a set of hand-worked cases pins known answers.
// -----------------------------------------------------------------------------
module tb_as_4b;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         v;
    } expT;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         mode;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int  errors = 0;
    int  checks = 0;
    expT expected = '0;

    as_4b #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer arithmetic: unsigned for result and carry/borrow,
    // signed range test for overflow.
    function automatic expT model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic m);
        expT e;
        int ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        if (!m) begin
            full = ua + ub;
            e.c  = (full >= (1 << W));
            sres = sa + sb;
        end else begin
            full = ua - ub + (1 << W);
            e.c  = (ua < ub);
            sres = sa - sb;
        end
        e.r = W'(full % (1 << W));
        e.o = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        e.z = (e.r == '0);
        e.v = 1'b1;
        return e;
    endfunction

    // Reference register: what the outputs must hold after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) expected = '0;
        else        expected = model(A, B, mode);
    end

    function automatic bit sameAs(input expT e);
        return (result === e.r) && (carry_out === e.c) && (overflow === e.o)
            && (zero === e.z) && (out_valid === e.v);
    endfunction

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        checks++;
        if (!sameAs(expected)) begin
            errors++;
            $display("[TB] FAIL model_cmp t=%0t: got r=%h c=%b o=%b z=%b v=%b, expected r=%h c=%b o=%b z=%b v=%b",
                     $time, result, carry_out, overflow, zero, out_valid,
                     expected.r, expected.c, expected.o, expected.z, expected.v);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m);
        @(posedge clk);
        #2;
        A    = a;
        B    = b;
        mode = m;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] r,
                               input logic c, input logic o, input logic z,
                               input logic v);
        expT e;
        e = '{r: r, c: c, o: o, z: z, v: v};
        checks++;
        if (!sameAs(e)) begin
            errors++;
            $display("[TB] FAIL %s: got r=%h c=%b o=%b z=%b v=%b, expected r=%h c=%b o=%b z=%b v=%b",
                     name, result, carry_out, overflow, zero, out_valid, r, c, o, z, v);
        end
    endtask

    task automatic runCase(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic m,
                           input logic [W-1:0] r, input logic c,
                           input logic o, input logic z);
        applyStimulus(a, b, m);
        @(posedge clk);
        #1;
        checkOutput(name, r, c, o, z, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 'x;
        B     = 'x;
        mode  = 1'bx;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_x_inputs", 4'h0, 0, 0, 0, 0);
        A    = 4'hF;
        B    = 4'hF;
        mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 4'h0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 4'hE, 1, 0, 0, 1);

        runCase("add_3_5",   4'b0011, 4'b0101, 0, 4'b1000, 0, 1, 0);
        runCase("add_c_3",   4'b1100, 4'b0011, 0, 4'b1111, 0, 0, 0);
        runCase("sub_5_3",   4'b0101, 4'b0011, 1, 4'b0010, 0, 0, 0);
        runCase("sub_8_6",   4'b1000, 4'b0110, 1, 4'b0010, 0, 1, 0);
        runCase("sub_3_5",   4'b0011, 4'b0101, 1, 4'b1110, 1, 0, 0);
        runCase("add_wrap",  4'b1111, 4'b0001, 0, 4'b0000, 1, 0, 1);
        runCase("sub_equal", 4'b0111, 4'b0111, 1, 4'b0000, 0, 0, 1);
        runCase("add_7_1",   4'b0111, 4'b0001, 0, 4'b1000, 0, 1, 0);

        // Back-to-back random operations, one per cycle.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2;
            A    = W'($urandom_range(0, (1 << W) - 1));
            B    = W'($urandom_range(0, (1 << W) - 1));
            mode = 1'($urandom_range(0, 1));
        end

        // Asynchronous reset between edges, then release with new operands.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midstream_clear", 4'h0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        A     = 4'h9;
        B     = 4'h4;
        mode  = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_release", 4'h5, 0, 1, 0, 1);

        // Exhaustive sweep, one combination per cycle.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    @(posedge clk);
                    #2;
                    A    = W'(a);
                    B    = W'(b);
                    mode = 1'(m);
                end
            end
        end

        // Random tail with occasional mode flips.
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #2;
            A    = W'($urandom);
            B    = W'($urandom);
            mode = 1'($urandom);
        end

        repeat (2) @(posedge clk);
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_as_4b

// File: doc/as_4b.md
# as_4b

Registered 4-bit adder/subtractor for datapath arithmetic. A mode input selects A+B or A−B. The block is a ripple-carry chain of full adders with B conditionally inverted, followed by an output register stage. It also produces carry/borrow, signed-overflow and zero flags for downstream control logic.

## Interface
- WIDTH, 4, operand and result width in bits; WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B, unsigned or two's complement.
- mode  input  1  0 = add (A+B); 1 = subtract (A−B).
- result  output  WIDTH  registered sum or difference, modulo 2^WIDTH.
- carry_out  output  1  registered carry in add mode; registered borrow in subtract mode.
- overflow  output  1  registered two's-complement overflow.
- zero  output  1  registered flag, 1 when result == 0.
- out_valid  output  1  0 during reset; 1 from the first clock edge after reset release.

## Operation
- Internal operand: Bx = B XOR {WIDTH{mode}}.
- Carry-in to bit 0 equals mode.
- Raw sum: {c_WIDTH, s} = A + Bx + mode.
- Add mode:
  - result = (A+B) mod 2^WIDTH.
  - carry_out = c_WIDTH, i.e. 1 iff A+B ≥ 2^WIDTH.
- Subtract mode:
  - result = (A−B) mod 2^WIDTH.
  - carry_out = NOT c_WIDTH. It is the borrow: 1 iff A < B unsigned.
  - A == B gives result 0, carry_out 0.
- overflow = c_WIDTH XOR c_(WIDTH−1), where c_(WIDTH−1) is the carry into the MSB. This is valid for both modes.
- zero is computed from the sum s, not from the registered result, so it is aligned with result.
- Operands are unconstrained; every combination of A, B and mode is legal.
- There is no handshake. A new operation may be presented every cycle.

## Timing
- All outputs are registered together on the rising edge of clk.
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- Throughput: one operation per cycle.
- Reset:
  - rst_n low immediately forces result = 0, carry_out = 0, overflow = 0, zero = 0 and out_valid = 0, independent of clk.
  - After release, the first rising edge loads live values and sets out_valid = 1.
  - Reset asserted mid-stream discards the in-flight operation. The first post-release edge loads whatever operands are on the inputs at that time.
- A mode change takes effect at the next edge with no extra latency.
- X on the inputs must not corrupt the reset values while rst_n is low.

## Structure
- Sub-module full_adder: inputs a, b, cin; outputs s, cout.
- A generate loop instantiates WIDTH copies in a ripple chain.
- Top level holds:
  - the B-inversion XOR and carry-in selection;
  - flag logic: borrow inversion, overflow XOR, zero reduction-NOR;
  - the output register.
- The shared package contains:
  - a mode constant pair, MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - the default width constant, AS_WIDTH = 4.
- No state machine.

## Test plan
- Reset: hold rst_n = 0 with A = 4'hF, B = 4'hF, mode = 0 → all outputs 0 and out_valid = 0. Release rst_n → after the next edge, result = 4'hE, carry_out = 1, out_valid = 1.
- Add: A = 0011, B = 0101, mode = 0 → result 1000, carry 0, overflow 1 (3+5 overflows signed 4-bit). A = 1100, B = 0011 → result 1111, carry 0, overflow 0.
- Subtract:
  - A = 0101, B = 0011, mode = 1 → result 0010, borrow 0.
  - A = 1000, B = 0110 → result 0010, borrow 0, overflow 1 (−8−6 overflows).
  - A = 0011, B = 0101 → result 1110, borrow 1.
- Wrap and zero: A = 1111, B = 0001, mode = 0 → result 0000, carry 1, zero 1. A = 0111, B = 0111, mode = 1 → result 0000, borrow 0, zero 1.
- Latency: change operands every cycle for 16 cycles → each output set equals the golden model of the previous edge's inputs.
- Mid-stream reset: assert rst_n asynchronously between edges → outputs clear immediately. After release, the first edge reflects the current inputs.
- Exhaustive sweep of all 512 combinations of A, B and mode, checked against the golden model.
